uart_rx_os: RTL and testbench

//  Parametrised oversampling UART receiver; successor to the fixed 8-bit, externally paced receiver.
//  - Integrated fractional-free tick generator, majority-vote sampling, 5..9 data bits, 1/2 stop bits.
//  - Framing/parity/overrun/break detection; valid/accept output handshake with one holding register.
//  - Sits between the board RXD pin and the command decoder / register-access layer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_os_tick.sv | 42 ++++
 rtl/uart_rx_os.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM encoding and the 3-sample majority vote.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_EVEN = 2'b01;
   localparam logic [1:0] PARITY_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_DELIVER,
      ST_BRK_WAIT
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: down-counter reloaded from a divisor latched at each restart.
module uart_os_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;

   // NOTE: every always_comb output gets its default first, so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      div_d = div_q;
      if (restart_i) begin
         cnt_d = div_i;
         div_d = div_i;
      end else if (cnt_q == '0) begin
         cnt_d = div_q;
      end else begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments only; blocking here would race other flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         div_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: rxd synchroniser, majority-vote bit sampling, framing/parity/break
// detection and a single holding register with a valid/accept handshake.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OS_RATE     = 16,
   parameter int SYNC_STAGES = 3,
   parameter int DIV_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rxd_input,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_accept,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 break_det,
   output logic                 busy
);

   localparam int              OS_W     = $clog2(OS_RATE);
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OS_RATE - 1);
   localparam logic [OS_W-1:0] SAMP_A   = OS_W'(OS_RATE / 2 - 1);
   localparam logic [OS_W-1:0] SAMP_B   = OS_W'(OS_RATE / 2);
   localparam logic [OS_W-1:0] SAMP_C   = OS_W'(OS_RATE / 2 + 1);
   localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

   // NOTE: reset asserts asynchronously but is released through two flops so no flop sees a
   // release edge close to clk.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_prev_q;
   logic                   rxd_s, fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd_input};
         rxd_prev_q <= rxd_s;
      end
   end
   assign rxd_s = sync_q[SYNC_STAGES-1];
   assign fall  = rxd_prev_q & ~rxd_s;

   rx_state_e            state_q, state_d;
   logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
   logic [OS_W-1:0]      hi_cnt_q, hi_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           par_mode_q, par_mode_d;
   logic                 two_stop_q, two_stop_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;
   logic                 zero_q, zero_d, last_stop_q, last_stop_d;

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d, hperr_q, hperr_d, hferr_q, hferr_d;
   logic                 ovr_q, ovr_d, brk_q, brk_d;

   logic tick, restart, vote, vote_ev, par_x;

   assign restart = (state_q == ST_IDLE) && fall;
   assign vote    = maj3(samp_q[0], samp_q[1], rxd_s);
   assign vote_ev = tick && (os_cnt_q == SAMP_C);
   assign par_x   = (^shift_q) ^ vote;

   uart_os_tick #(.DIV_W(DIV_W)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart_i (restart),
      .div_i     (baud_div),
      .tick_o    (tick)
   );

   always_comb begin
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      samp_d      = samp_q;
      shift_d     = shift_q;
      par_mode_d  = par_mode_q;
      two_stop_d  = two_stop_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      zero_d      = zero_q;
      last_stop_d = last_stop_q;

      if (tick && state_q != ST_IDLE) begin
         os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
         if (os_cnt_q == SAMP_A) samp_d[0] = rxd_s;
         if (os_cnt_q == SAMP_B) samp_d[1] = rxd_s;
      end

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d    = ST_START;
               os_cnt_d   = '0;
               bit_cnt_d  = '0;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
               zero_d     = 1'b1;
               two_stop_d = two_stop;
               par_mode_d = (parity_mode == PARITY_EVEN || parity_mode == PARITY_ODD)
                            ? parity_mode : PARITY_NONE;
            end
         end
         ST_START: begin
            if (vote_ev) state_d = vote ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (vote_ev) begin
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
               zero_d  = zero_q & ~vote;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = (par_mode_q != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (vote_ev) begin
               perr_d  = (par_mode_q == PARITY_EVEN) ? par_x : ~par_x;
               zero_d  = zero_q & ~vote;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (vote_ev) begin
               zero_d      = zero_q & ~vote;
               ferr_d      = ferr_q | ~vote;
               last_stop_d = vote;
               if (two_stop_q && bit_cnt_q == 4'd0) bit_cnt_d = 4'd1;
               else                                 state_d   = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            hi_cnt_d = '0;
            state_d  = (zero_q || !last_stop_q) ? ST_BRK_WAIT : ST_IDLE;
         end
         ST_BRK_WAIT: begin
            // A held-low line yields one word; wait for a full bit time of idle before re-arming.
            if (tick) begin
               if (!rxd_s)                  hi_cnt_d = '0;
               else if (hi_cnt_q == OS_LAST) state_d  = ST_IDLE;
               else                         hi_cnt_d = hi_cnt_q + OS_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      hperr_d = hperr_q;
      hferr_d = hferr_q;
      ovr_d   = ovr_q;
      brk_d   = brk_q;
      if (valid_q && rx_accept) valid_d = 1'b0;
      if (state_q == ST_DELIVER) begin
         if (!valid_q || rx_accept) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            hperr_d = perr_q;
            hferr_d = ferr_q;
            brk_d   = zero_q;
            ovr_d   = 1'b0;
         end else begin
            ovr_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         os_cnt_q    <= '0;
         hi_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         samp_q      <= '0;
         shift_q     <= '0;
         par_mode_q  <= PARITY_NONE;
         two_stop_q  <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         zero_q      <= 1'b0;
         last_stop_q <= 1'b1;
         data_q      <= '0;
         valid_q     <= 1'b0;
         hperr_q     <= 1'b0;
         hferr_q     <= 1'b0;
         ovr_q       <= 1'b0;
         brk_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         samp_q      <= samp_d;
         shift_q     <= shift_d;
         par_mode_q  <= par_mode_d;
         two_stop_q  <= two_stop_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         zero_q      <= zero_d;
         last_stop_q <= last_stop_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         hperr_q     <= hperr_d;
         hferr_q     <= hferr_d;
         ovr_q       <= ovr_d;
         brk_q       <= brk_d;
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign parity_err = hperr_q;
   assign frame_err  = hferr_q;
   assign overrun    = ovr_q;
   assign break_det  = brk_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven bit-by-bit on rxd_input, held word checked.
module tb_uart_rx_os;

   localparam int DIV = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rxd_input = 1'b1;
   logic [15:0] baud_div = 16'(DIV);
   logic [1:0]  parity_mode = 2'b00;
   logic        two_stop = 1'b0;
   logic        rx_accept = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid, parity_err, frame_err, overrun, break_det, busy;

   int errors = 0;
   int checks = 0;
   int bit_clks = 16 * (DIV + 1);
   // Cycle (counted in posedges from the start-bit drive) in which the FSM sits in DELIVER for
   // an 8N1 frame: 3 sync + 1 edge flop, DIV+1 to first tick, stop-bit vote at tick 9*16+9, +1.
   int acc_cyc   = 5 + DIV + (9 * 16 + 9) * (DIV + 1);
   // Offset into a bit at which a one-tick spike covers only the middle vote sample.
   int spike_off = 9 * (DIV + 1) - 2;

   uart_rx_os dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rxd_input   (rxd_input),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_accept   (rx_accept),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .break_det   (break_det),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [7:0] d, input bit pe, input bit fe,
                             input bit ov, input bit bk);
      check({tag, "/valid"}, 32'(rx_valid), 1);
      check({tag, "/data"}, 32'(rx_data), 32'(d));
      check({tag, "/perr"}, 32'(parity_err), 32'(pe));
      check({tag, "/ferr"}, 32'(frame_err), 32'(fe));
      check({tag, "/ovr"}, 32'(overrun), 32'(ov));
      check({tag, "/brk"}, 32'(break_det), 32'(bk));
   endtask

   // Caller must be at a negedge; each level lasts exactly bit_clks clocks, two idle bits follow.
   task automatic drive_frame(input logic [7:0] data, input bit par_en, input bit par_bit,
                              input bit stop1, input bit stop2_en, input bit stop2);
      logic [15:0] bits;
      int          n;
      bits = '0;
      n = 1;
      for (int i = 0; i < 8; i++) begin
         bits[n] = data[i];
         n++;
      end
      if (par_en) begin
         bits[n] = par_bit;
         n++;
      end
      bits[n] = stop1;
      n++;
      if (stop2_en) begin
         bits[n] = stop2;
         n++;
      end
      bits[n] = 1'b1;
      bits[n+1] = 1'b1;
      n += 2;
      for (int i = 0; i < n; i++) begin
         rxd_input = bits[i];
         repeat (bit_clks) @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] data);
      @(negedge clk);
      drive_frame(data, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic accept_word();
      @(negedge clk);
      rx_accept = 1'b1;
      @(negedge clk);
      rx_accept = 1'b0;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("rst/valid", 32'(rx_valid), 0);
      check("rst/data", 32'(rx_data), 0);
      check("rst/flags", 32'({parity_err, frame_err, overrun, break_det}), 0);
      check("rst/busy", 32'(busy), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: plain 8N1, word held without accept
      send(8'hA5);
      check_word("t1", 8'hA5, 0, 0, 0, 0);
      repeat (bit_clks) @(negedge clk);
      check("t1/hold", 32'(rx_valid), 1);
      check("t1/holddata", 32'(rx_data), 32'hA5);
      accept_word();
      check("t1/clr", 32'(rx_valid), 0);

      // fastest divisor: tick every clock
      baud_div = 16'd0;
      bit_clks = 16;
      send(8'h5A);
      check_word("div0", 8'h5A, 0, 0, 0, 0);
      accept_word();
      baud_div = 16'(DIV);
      bit_clks = 16 * (DIV + 1);

      // 2: parity
      parity_mode = 2'b01;
      @(negedge clk);
      drive_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_word("t2even", 8'h3C, 1, 0, 0, 0);
      accept_word();
      parity_mode = 2'b10;
      @(negedge clk);
      drive_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_word("t2odd", 8'h3C, 0, 0, 0, 0);
      accept_word();
      parity_mode = 2'b00;

      // 3: framing errors
      @(negedge clk);
      drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t3stop", 8'h81, 0, 1, 0, 0);
      check("t3stop/busy", 32'(busy), 0);
      accept_word();
      two_stop = 1'b1;
      @(negedge clk);
      drive_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_word("t3stop2", 8'h42, 0, 1, 0, 0);
      accept_word();
      @(negedge clk);
      drive_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check_word("t3two", 8'h42, 0, 0, 0, 0);
      accept_word();
      two_stop = 1'b0;

      // 4: break, one word only, then recovery
      @(negedge clk);
      rxd_input = 1'b0;
      repeat (11 * bit_clks) @(negedge clk);
      check_word("t4brk", 8'h00, 0, 1, 0, 1);
      accept_word();
      repeat (18 * bit_clks) @(negedge clk);
      check("t4/one", 32'(rx_valid), 0);
      check("t4/busy", 32'(busy), 1);
      rxd_input = 1'b1;
      repeat (2 * bit_clks) @(negedge clk);
      check("t4/idle", 32'(busy), 0);
      send(8'h55);
      check_word("t4next", 8'h55, 0, 0, 0, 0);
      accept_word();

      // 5: overrun, then accept coinciding with the load of a third frame
      send(8'h11);
      send(8'h22);
      check_word("t5ovr", 8'h11, 0, 0, 1, 0);
      @(negedge clk);
      fork
         drive_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         begin
            repeat (acc_cyc) @(posedge clk);
            #1 rx_accept = 1'b1;
            @(posedge clk);
            #1 rx_accept = 1'b0;
         end
      join
      check_word("t5acc", 8'h33, 0, 0, 0, 0);
      accept_word();

      // 6: start glitch, mid-bit spike, reset mid-frame
      @(negedge clk);
      rxd_input = 1'b0;
      repeat (2 * (DIV + 1)) @(negedge clk);
      rxd_input = 1'b1;
      repeat (2 * bit_clks) @(negedge clk);
      check("t6glitch/valid", 32'(rx_valid), 0);
      check("t6glitch/busy", 32'(busy), 0);
      @(negedge clk);
      fork
         drive_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         begin
            repeat (4 * bit_clks + spike_off) @(negedge clk);
            rxd_input = 1'b1;
            repeat (DIV + 1) @(negedge clk);
            rxd_input = 1'b0;
         end
      join
      check_word("t6spike", 8'hF0, 0, 0, 0, 0);
      accept_word();
      @(negedge clk);
      fork
         drive_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         begin
            repeat (5 * bit_clks + bit_clks / 2) @(negedge clk);
            reset_n = 1'b0;
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
         end
      join
      check("t6rst/valid", 32'(rx_valid), 0);
      check("t6rst/busy", 32'(busy), 0);
      check("t6rst/data", 32'(rx_data), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
